// File: rtl/display_timing_pkg.sv
// Shared phase type and 1280x1024@60 timing constants for the display raster generator.
package display_timing_pkg;

   typedef enum logic [1:0] {PhActive, PhFp, PhSync, PhBp} phase_e;

   localparam int unsigned CntW = 11;

   localparam int unsigned H_ACTIVE = 1280;
   localparam int unsigned H_FP     = 48;
   localparam int unsigned H_SYNC   = 112;
   localparam int unsigned H_BP     = 248;
   localparam int unsigned V_ACTIVE = 1024;
   localparam int unsigned V_FP     = 1;
   localparam int unsigned V_SYNC   = 3;
   localparam int unsigned V_BP     = 38;
   localparam bit          SYNC_POL = 1'b1;

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   function automatic phase_e next_phase(input phase_e p);
      phase_e n;
      unique case (p)
         PhActive: n = PhFp;
         PhFp:     n = PhSync;
         PhSync:   n = PhBp;
         PhBp:     n = PhActive;
         default:  n = PhActive;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// Pixel-enable and raster output bundle; DISPLAY_FRAME_CNT_EN adds the frame counter signals.
interface display_timing_gen_if;
   logic        pixel_en;
   logic [10:0] x;
   logic [9:0]  y;
   logic        valid;
   logic        hsync;
   logic        vsync;
   logic        vblank;
`ifdef DISPLAY_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   logic        frame_start;
`endif

   modport master (
      input  pixel_en,
`ifdef DISPLAY_FRAME_CNT_EN
      output frame_cnt,
      output frame_start,
`endif
      output x, y, valid, hsync, vsync, vblank
   );

   modport slave (
      output pixel_en,
`ifdef DISPLAY_FRAME_CNT_EN
      input  frame_cnt,
      input  frame_start,
`endif
      input  x, y, valid, hsync, vsync, vblank
   );
endinterface

// File: rtl/timing_axis.sv
// One raster axis: four-phase FSM with per-phase counter plus an absolute position counter.
module timing_axis
   import display_timing_pkg::*;
#(
   parameter int unsigned Active = 8,
   parameter int unsigned Fp     = 1,
   parameter int unsigned Sync   = 1,
   parameter int unsigned Bp     = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            adv_i,
   output phase_e          phase_o,
   output logic [CntW-1:0] cnt_o,
   output logic            wrap_o
);

   phase_e          phase_q, phase_d;
   logic [CntW-1:0] ph_cnt_q, ph_cnt_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ph_last;

   always_comb begin
      ph_last = 1'b0;
      unique case (phase_q)
         PhActive: ph_last = (ph_cnt_q == CntW'(Active - 1));
         PhFp:     ph_last = (ph_cnt_q == CntW'(Fp - 1));
         PhSync:   ph_last = (ph_cnt_q == CntW'(Sync - 1));
         PhBp:     ph_last = (ph_cnt_q == CntW'(Bp - 1));
         default:  ph_last = 1'b0;
      endcase
   end

   // End of back porch is the end of the axis; position wraps with it.
   assign wrap_o = adv_i && (phase_q == PhBp) && ph_last;

   always_comb begin
      phase_d  = phase_q;
      ph_cnt_d = ph_cnt_q;
      cnt_d    = cnt_q;
      if (adv_i) begin
         if (ph_last) begin
            phase_d  = next_phase(phase_q);
            ph_cnt_d = '0;
         end else begin
            ph_cnt_d = ph_cnt_q + 1'b1;
         end
         cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q  <= PhActive;
         ph_cnt_q <= '0;
         cnt_q    <= '0;
      end else begin
         phase_q  <= phase_d;
         ph_cnt_q <= ph_cnt_d;
         cnt_q    <= cnt_d;
      end
   end

   assign phase_o = phase_q;
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator (default 1280x1024@60) advancing on pixel_en with registered outputs.
// Optional frame counter/frame_start outputs are built when DISPLAY_FRAME_CNT_EN is defined.
module display_timing_gen
   import display_timing_pkg::*;
#(
   parameter int unsigned HActive = H_ACTIVE,
   parameter int unsigned HFp     = H_FP,
   parameter int unsigned HSync   = H_SYNC,
   parameter int unsigned HBp     = H_BP,
   parameter int unsigned VActive = V_ACTIVE,
   parameter int unsigned VFp     = V_FP,
   parameter int unsigned VSync   = V_SYNC,
   parameter int unsigned VBp     = V_BP,
   parameter bit          SyncPol = SYNC_POL
) (
   input logic                  clk,
   input logic                  reset,
   display_timing_gen_if.master disp
);

   phase_e          h_phase, v_phase;
   logic [CntW-1:0] h_cnt, v_cnt;
   logic            h_wrap;

   timing_axis #(.Active(HActive), .Fp(HFp), .Sync(HSync), .Bp(HBp)) u_h_axis (
      .clk     (clk),
      .reset   (reset),
      .adv_i   (disp.pixel_en),
      .phase_o (h_phase),
      .cnt_o   (h_cnt),
      .wrap_o  (h_wrap)
   );

`ifdef DISPLAY_FRAME_CNT_EN
   logic v_wrap;
`endif

   timing_axis #(.Active(VActive), .Fp(VFp), .Sync(VSync), .Bp(VBp)) u_v_axis (
      .clk     (clk),
      .reset   (reset),
      .adv_i   (h_wrap),
      .phase_o (v_phase),
      .cnt_o   (v_cnt),
`ifdef DISPLAY_FRAME_CNT_EN
      .wrap_o  (v_wrap)
`else
      .wrap_o  ()
`endif
   );

   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;
   logic        h_act, v_act;

   // Phases, not counter compares, decide sync/valid; counters only supply coordinates.
   always_comb begin
      h_act    = (h_phase == PhActive);
      v_act    = (v_phase == PhActive);
      x_d      = h_act ? h_cnt : '0;
      y_d      = v_act ? 10'(v_cnt) : '0;
      valid_d  = h_act && v_act;
      hsync_d  = (h_phase == PhSync) ? SyncPol : ~SyncPol;
      vsync_d  = (v_phase == PhSync) ? SyncPol : ~SyncPol;
      vblank_d = !v_act;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q      <= '0;
         y_q      <= '0;
         valid_q  <= 1'b0;
         hsync_q  <= ~SyncPol;
         vsync_q  <= ~SyncPol;
         vblank_q <= 1'b0;
      end else if (disp.pixel_en) begin
         x_q      <= x_d;
         y_q      <= y_d;
         valid_q  <= valid_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         vblank_q <= vblank_d;
      end
   end

   assign disp.x      = x_q;
   assign disp.y      = y_q;
   assign disp.valid  = valid_q;
   assign disp.hsync  = hsync_q;
   assign disp.vsync  = vsync_q;
   assign disp.vblank = vblank_q;

`ifdef DISPLAY_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;
   logic        frame_start_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_cnt_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         if (v_wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (disp.pixel_en) frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

   assign disp.frame_cnt   = frame_cnt_q;
   assign disp.frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench: full-size generator plus a shrunken-timing instance checked tick by tick against
// an arithmetic raster model; honours DISPLAY_FRAME_CNT_EN.
module tb_display_timing_gen;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic pen = 1'b1;

   always #5 clk = ~clk;

   display_timing_gen_if big_if ();
   display_timing_gen_if sml_if ();

   assign big_if.pixel_en = pen;
   assign sml_if.pixel_en = pen;

   display_timing_gen dut (
      .clk   (clk),
      .reset (reset),
      .disp  (big_if)
   );

   display_timing_gen #(
      .HActive(8), .HFp(2), .HSync(3), .HBp(4),
      .VActive(6), .VFp(1), .VSync(2), .VBp(3), .SyncPol(1'b1)
   ) dut_s (
      .clk   (clk),
      .reset (reset),
      .disp  (sml_if)
   );

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic        valid;
      logic        hsync;
      logic        vsync;
      logic        vblank;
      logic [15:0] fcnt;
      logic        fstart;
   } exp_t;

   int vectors = 0;
   int misc = 0;
   int n = 0;  // pixel ticks since the last reset edge

   // Outputs after n ticks show the raster position reached after n-1 ticks.
   function automatic exp_t model(input int nt, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs,
                                  input int vb);
      exp_t e;
      int ht, vt, fr, p, h, v;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      fr = ht * vt;
      if (nt == 0) begin
         e.x = '0; e.y = '0; e.valid = 1'b0; e.hsync = 1'b0; e.vsync = 1'b0;
         e.vblank = 1'b0; e.fcnt = '0; e.fstart = 1'b0;
         return e;
      end
      p = (nt - 1) % fr;
      h = p % ht;
      v = p / ht;
      e.valid  = (h < ha) && (v < va);
      e.x      = (h < ha) ? 11'(h) : 11'd0;
      e.y      = (v < va) ? 10'(v) : 10'd0;
      e.hsync  = (h >= ha + hf) && (h < ha + hf + hs);
      e.vsync  = (v >= va + vf) && (v < va + vf + vs);
      e.vblank = (v >= va);
      e.fcnt   = 16'(nt / fr);
      e.fstart = (p == 0);
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         misc++;
         $error("FAIL %s: observed %0h expected %0h (tick %0d, t=%0t)", tag, got, exp, n, $time);
      end
   endtask

   task automatic check_all();
      exp_t eb, es;
      eb = model(n, 1280, 48, 112, 248, 1024, 1, 3, 38);
      es = model(n, 8, 2, 3, 4, 6, 1, 2, 3);
      cmp("big.x",      16'(big_if.x),      16'(eb.x));
      cmp("big.y",      16'(big_if.y),      16'(eb.y));
      cmp("big.valid",  16'(big_if.valid),  16'(eb.valid));
      cmp("big.hsync",  16'(big_if.hsync),  16'(eb.hsync));
      cmp("big.vsync",  16'(big_if.vsync),  16'(eb.vsync));
      cmp("big.vblank", 16'(big_if.vblank), 16'(eb.vblank));
      cmp("sml.x",      16'(sml_if.x),      16'(es.x));
      cmp("sml.y",      16'(sml_if.y),      16'(es.y));
      cmp("sml.valid",  16'(sml_if.valid),  16'(es.valid));
      cmp("sml.hsync",  16'(sml_if.hsync),  16'(es.hsync));
      cmp("sml.vsync",  16'(sml_if.vsync),  16'(es.vsync));
      cmp("sml.vblank", 16'(sml_if.vblank), 16'(es.vblank));
`ifdef DISPLAY_FRAME_CNT_EN
      cmp("big.frame_cnt",   big_if.frame_cnt,          eb.fcnt);
      cmp("big.frame_start", 16'(big_if.frame_start),   16'(eb.fstart));
      cmp("sml.frame_cnt",   sml_if.frame_cnt,          es.fcnt);
      cmp("sml.frame_start", 16'(sml_if.frame_start),   16'(es.fstart));
`endif
   endtask

   task automatic step(input logic rst_n, input logic en);
      @(negedge clk);
      reset = rst_n;
      pen   = en;
      @(posedge clk);
      if (!rst_n) n = 0;
      else if (en) n++;
      #1;
      check_all();
   endtask

   initial begin
      // Reset held with pixel_en high.
      repeat (5) step(1'b0, 1'b1);

      step(1'b1, 1'b1);
      cmp("first.valid", 16'(big_if.valid), 16'd1);
      cmp("first.x",     16'(big_if.x),     16'd0);
      cmp("first.y",     16'(big_if.y),     16'd0);

      // Two full lines and a bit at full rate; small instance wraps many frames meanwhile.
      repeat (2 * 1688 + 20) step(1'b1, 1'b1);
      cmp("line2.y", 16'(big_if.y), 16'd2);

      // Sparse pixel enables, roughly one in three.
      repeat (3000) step(1'b1, 1'($urandom_range(0, 2) == 0));

      // Run to column 700 of the current line, then a single reset edge.
      for (int i = 0; i < 2000 && ((n - 1) % 1688) != 700; i++) step(1'b1, 1'b1);
      cmp("pre_reset.col", 16'((n - 1) % 1688), 16'd700);
      step(1'b0, 1'($urandom_range(0, 1)));
      cmp("mid_reset.hsync", 16'(big_if.hsync), 16'd0);

      repeat (1700) step(1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
Generates 1280x1024@60 raster timing that feeds the waveform display top level.
- Outputs pixel coordinates x/y, the valid strobe, hsync/vsync and a vertical-blank flag.
- vblank drives the capture block's idle input.
- Pixel rate is set by a clock-enable (pixel_en), so one system clock serves both pixel-rate and fast-clock builds.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 48, horizontal front porch (pixel ticks)
H_SYNC, 112, hsync pulse width
H_BP, 248, horizontal back porch
V_ACTIVE, 1024, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vsync pulse width
V_BP, 38, vertical back porch
SYNC_POL, 1, asserted level of hsync/vsync (1 = positive)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
pixel_en  in  1  pixel tick; timing advances only when high
x  out  11  pixel column [0..1279]; 0 outside active area
y  out  10  pixel row [0..1023]; 0 outside active area
valid  out  1  high when x/y lie in the active area
hsync  out  1  horizontal sync at SYNC_POL
vsync  out  1  vertical sync at SYNC_POL
vblank  out  1  high for lines >= V_ACTIVE

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = 1688.
  - v_cnt runs 0..V_TOTAL-1, with V_TOTAL = 1066.
  - Both counters are 11 bits wide.
- Per-edge update:
  - On a rising clk with reset=1 and pixel_en=1, the outputs register decode(h_cnt, v_cnt).
  - On the same edge, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1.
- Latency: outputs lag the counters by exactly one pixel tick. All outputs are registered, with no combinational paths from inputs.
- When pixel_en=0, counters and outputs hold.
- Decode:
  - valid = (h < H_ACTIVE) && (v < V_ACTIVE).
  - x = h when h < H_ACTIVE, else 0.
  - y = v[9:0] when v < V_ACTIVE, else 0.
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [1328, 1440).
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [1025, 1028). This covers whole lines, so the edge coincides with h = 0.
  - vblank = v >= V_ACTIVE.
- Horizontal phase FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
  - Transitions occur when a phase counter reaches its length minus 1 on a pixel tick.
  - A vertical FSM with the same four phases advances only on the horizontal wrap.
  - The FSM phase is authoritative for hsync/vsync/valid; h_cnt supplies x.
- Reset (reset=0 at an edge, regardless of pixel_en):
  - Counters go to 0 and both FSMs go to ACTIVE.
  - Outputs: x=0, y=0, valid=0, vblank=0, hsync=!SYNC_POL, vsync=!SYNC_POL.
  - Reset mid-frame restarts at (0,0) on the next edge, with no partial sync pulse extended.
- First tick after reset: valid=1, x=0, y=0.
- Frame period is exactly 1688*1066 = 1,799,408 pixel ticks.
- Counters never exceed TOTAL-1; unused counter values are unreachable.

Optional Feature:
- Macro: DISPLAY_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt [15:0], which increments (mod 2^16) on the tick where both counters wrap to (0,0).
  - Adds output frame_start [1], a one-pixel-tick pulse coincident with the outputs for (0,0).
  - Both reset to 0.
- When undefined: neither port nor the logic exists, and all other behaviour is identical.

Decomposition:
- Shared package display_timing_pkg holds:
  - the phase enum typedef (ACTIVE, FP, SYNC, BP);
  - default 1280x1024 timing constants;
  - derived H_TOTAL/V_TOTAL.
- One sub-module, timing_axis, is instantiated twice (horizontal and vertical).
  - It contains the phase FSM plus position counter.
  - It is parameterised by active/fp/sync/bp lengths.
  - Its advance input is pixel_en for horizontal, or the horizontal wrap for vertical.
  - It produces a wrap output, phase and count.

Test Plan:
- Reset held 5 clks with pixel_en=1 -> x=0, y=0, valid=0, vblank=0, hsync=vsync=0. First tick after release -> valid=1, x=0, y=0.
- pixel_en=1 constantly, line 0:
  - valid high for 1280 ticks, with x reaching 1279;
  - hsync rises at output tick 1328, is high for 112 ticks, and falls at 1440;
  - the next line starts at tick 1688 with y=1.
- Full frame:
  - vblank rises at line 1024;
  - vsync covers lines 1025-1027 (3*1688 ticks);
  - y returns to 0 after 1,799,408 ticks.
- pixel_en toggled 1-in-3 -> identical output sequence stretched ×3; outputs stable on pixel_en=0 cycles.
- Reset asserted at (x=700, y=500) for 1 clk -> outputs reset, then restart at (0,0) with a correct line length.
- With DISPLAY_FRAME_CNT_EN -> frame_start pulses once per 1,799,408 ticks; frame_cnt goes 0→1→2 over two frames.
